dsp_addsub_arbiter: RTL and testbench
=====================================

Name: dsp_addsub_arbiter

Overview:
- Shares a single SB_MAC16-based 32-bit add/subtract datapath between two requesters, e.g. the ALU and the branch-target adder.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates between requesters, latches the winner's operands, drives the DSP and captures result and carry-out.
- Sits beside the ALU in the processor datapath, so the design spends one DSP tile on add/sub instead of two.

Parameters:
- DATA_WIDTH, 32: operand and result width; only 32 is supported, since it maps to the 2x16 DSP add/sub split.
- RR_INIT, 0: requester that holds priority after reset (0 or 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid_0 / req_valid_1  in  1  request present
- req_ready_0 / req_ready_1  out  1  request accepted this cycle
- req_a_0 / req_a_1  in  32  operand A (minuend for sub)
- req_b_0 / req_b_1  in  32  operand B
- req_op_0 / req_op_1  in  1  0 = A+B, 1 = A-B
- rsp_valid_0 / rsp_valid_1  out  1  result available for that requester
- rsp_ready_0 / rsp_ready_1  in  1  requester consumes result
- rsp_data  out  32  shared result bus, meaningful only with the owner's rsp_valid
- rsp_co  out  1  carry-out; for sub, 1 means A >= B unsigned (no borrow)

Behaviour:
- One clock domain, clk. rst is synchronous and active-high.
- Reset values: FSM in IDLE, all req_ready_* = 0, all rsp_valid_* = 0, rsp_data = 0, rsp_co = 0, priority pointer = RR_INIT.
- Reset mid-operation aborts any in-flight op and discards the result. No response is ever issued for it.
- FSM states:
  - IDLE: arbitrate; on grant go to EXEC.
  - EXEC: DSP evaluates the latched operands; result and carry are registered; go to RESP.
  - RESP: assert rsp_valid of the owner until its rsp_ready.
- Arbitration is combinational in IDLE, and in RESP in the cycle where the owner's rsp_ready = 1.
  - One requester valid: grant it.
  - Both valid: grant the requester pointed to by the priority pointer.
  - The pointer flips to the non-granted requester after every grant.
- req_ready_x is asserted only for the granted requester, only in a grant cycle. The handshake is req_valid_x & req_ready_x.
- A, B, op and owner id are latched on the handshake.
- Requesters must hold req_valid and the operands stable until ready. The block does not check this.
- Latency: handshake in cycle T, rsp_valid high from T+2.
- Back-to-back: in RESP, owner rsp_ready together with a pending request gives response retire and new grant in the same cycle, then EXEC. Peak throughput is one op per 2 cycles.
- In RESP without a grant, the FSM returns to IDLE.
- rsp_data and rsp_co hold their value while in RESP, even if the other requester toggles its inputs.
- Arithmetic is modulo 2^32.
  - add: {co, data} = A + B.
  - sub: {co, data} = A + ~B + 1.
  - Examples: 0xFFFFFFFF + 1 gives data 0, co 1. 0 - 1 gives 0xFFFFFFFF, co 0.
- Simultaneous events:
  - The owner's rsp_ready while rsp_valid is low is ignored.
  - A new request from the current owner is arbitrated normally against the other requester.

Optional Feature:
- Macro ADDSUB_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid. The priority pointer and RR_INIT are ignored, and requester 1 may starve.
- Undefined: round-robin as described above, which guarantees each requester a grant within 2 grants of its request.

Decomposition:
- Shared package holds:
  - op encodings ADDSUB_OP_ADD = 0, ADDSUB_OP_SUB = 1;
  - FSM state encodings ARB_IDLE, ARB_EXEC, ARB_RESP (2 bits);
  - requester id width (1).
- One sub-module, dsp_addsub32:
  - combinational wrapper around SB_MAC16 in 2x16 add/sub mode, inputs/outputs A, B, op, data, co;
  - ADDSUBTOP/ADDSUBBOT driven from op, carry chained bottom to top;
  - instantiated once; the arbiter owns all registers.

Test Plan:
- Reset then single request: req_0 with A=5, B=3, op=add, handshake at T → rsp_valid_0 at T+2 with data=8, co=0; rsp_valid_1 stays 0.
- Subtract with borrow: req_1 with A=0, B=1, op=sub → data=0xFFFFFFFF, co=0. Then A=7, B=7, op=sub → data=0, co=1.
- Contention: both valid every cycle with rsp_ready tied high → grants alternate 0,1,0,1 starting at RR_INIT, one op per 2 cycles. Under ADDSUB_ARB_FIXED_PRIO_EN, all grants go to 0.
- Response backpressure: rsp_ready_0 held low for 5 cycles → rsp_valid_0 and the data stay stable, req_ready_1 stays 0 despite req_valid_1, and the grant to 1 occurs in the cycle rsp_ready_0 rises.
- Overflow: A=0xFFFFFFFF, B=1, op=add → data=0, co=1. A=0x7FFFFFFF, B=0x80000001, op=add → data=0, co=1.
- Reset mid-operation: rst asserted in EXEC → next cycle all outputs at reset values, no rsp_valid for the aborted op, and the pointer is back at RR_INIT.

Source files
------------

// File: rtl/dsp_addsub_arbiter_pkg.sv
// dsp_addsub_arbiter_pkg: shared encodings for the add/sub arbiter and its DSP wrapper
package dsp_addsub_arbiter_pkg;
    localparam logic ADDSUB_OP_ADD = 1'b0;
    localparam logic ADDSUB_OP_SUB = 1'b1;
    localparam int REQ_ID_W = 1;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;
endpackage

// File: rtl/dsp_addsub_arbiter_dsp.sv
// dsp_addsub32: combinational 32-bit add/sub shaped as the SB_MAC16 2x16 split (bottom carry feeds top)
module dsp_addsub32
    import dsp_addsub_arbiter_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic [31:0] data,
    output logic        co
);
    logic        sub;
    logic        c_lo;
    logic [31:0] b_x;
    // ADDSUBBOT/ADDSUBTOP both follow op; subtract is A + ~B + 1 with the +1 injected at the bottom
    always_comb begin
        sub = (op == ADDSUB_OP_SUB);
        b_x = b ^ {32{sub}};
        {c_lo, data[15:0]} = {1'b0, a[15:0]} + {1'b0, b_x[15:0]} + {16'b0, sub};
        {co, data[31:16]} = {1'b0, a[31:16]} + {1'b0, b_x[31:16]} + {16'b0, c_lo};
    end
endmodule

// File: rtl/dsp_addsub_arbiter.sv
// dsp_addsub_arbiter: shares one add/sub DSP between two valid/ready requesters.
// ADDSUB_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins contention (no round-robin).
module dsp_addsub_arbiter
    import dsp_addsub_arbiter_pkg::*;
#(
    parameter int   DATA_WIDTH = 32,
    parameter logic RR_INIT    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_0,
    output logic                  req_ready_1,
    input  logic [DATA_WIDTH-1:0] req_a_0,
    input  logic [DATA_WIDTH-1:0] req_a_1,
    input  logic [DATA_WIDTH-1:0] req_b_0,
    input  logic [DATA_WIDTH-1:0] req_b_1,
    input  logic                  req_op_0,
    input  logic                  req_op_1,
    output logic                  rsp_valid_0,
    output logic                  rsp_valid_1,
    input  logic                  rsp_ready_0,
    input  logic                  rsp_ready_1,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_co
);
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif
    arb_state_t            state;
    logic [REQ_ID_W-1:0]   owner;
    logic                  ptr;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  op_q;
    logic [DATA_WIDTH-1:0] sum;
    logic                  sum_co;
    logic                  owner_ready;
    logic                  retire;
    logic                  gnt;
    logic                  gnt_id;

    dsp_addsub32 u_dsp (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .data (sum),
        .co   (sum_co)
    );

    // grant is possible when idle, or when the owner retires its response in the same cycle
    always_comb begin
        owner_ready = owner ? rsp_ready_1 : rsp_ready_0;
        retire      = (state == ARB_RESP) && owner_ready;
        gnt         = !rst && (state == ARB_IDLE || retire) && (req_valid_0 || req_valid_1);
        gnt_id      = (req_valid_0 && req_valid_1) ? (FIXED_PRIO ? 1'b0 : ptr) : req_valid_1;
        req_ready_0 = gnt && !gnt_id;
        req_ready_1 = gnt && gnt_id;
    end

    // FSM: latch the winner, register the DSP result in EXEC, hold it in RESP until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            owner       <= '0;
            ptr         <= RR_INIT;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= ADDSUB_OP_ADD;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_data    <= '0;
            rsp_co      <= 1'b0;
        end else begin
            if (gnt) begin
                owner <= gnt_id;
                a_q   <= gnt_id ? req_a_1 : req_a_0;
                b_q   <= gnt_id ? req_b_1 : req_b_0;
                op_q  <= gnt_id ? req_op_1 : req_op_0;
                ptr   <= !gnt_id;
                state <= ARB_EXEC;
            end else if (retire) begin
                state <= ARB_IDLE;
            end
            if (retire) begin
                rsp_valid_0 <= 1'b0;
                rsp_valid_1 <= 1'b0;
            end
            if (state == ARB_EXEC) begin
                rsp_data    <= sum;
                rsp_co      <= sum_co;
                rsp_valid_0 <= !owner;
                rsp_valid_1 <= owner;
                state       <= ARB_RESP;
            end
        end
    end
endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// tb_dsp_addsub_arbiter: scoreboard bench for the shared add/sub arbiter
module tb_dsp_addsub_arbiter;
    import dsp_addsub_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic        req_op_0, req_op_1;
    logic        rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
    logic [31:0] rsp_data;
    logic        rsp_co;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        co;
    } exp_t;

    exp_t        q[$];
    logic        glog[$];
    int          gcyc[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    logic        hs0 = 1'b0;
    logic        hs1 = 1'b0;
    logic        prev_v = 1'b0;
    exp_t        e;
    logic [32:0] r;
    logic [31:0] cap;

    dsp_addsub_arbiter #(.DATA_WIDTH(32), .RR_INIT(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_0 (req_valid_0),
        .req_valid_1 (req_valid_1),
        .req_ready_0 (req_ready_0),
        .req_ready_1 (req_ready_1),
        .req_a_0     (req_a_0),
        .req_a_1     (req_a_1),
        .req_b_0     (req_b_0),
        .req_b_1     (req_b_1),
        .req_op_0    (req_op_0),
        .req_op_1    (req_op_1),
        .rsp_valid_0 (rsp_valid_0),
        .rsp_valid_1 (rsp_valid_1),
        .rsp_ready_0 (rsp_ready_0),
        .rsp_ready_1 (rsp_ready_1),
        .rsp_data    (rsp_data),
        .rsp_co      (rsp_co)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
        return op ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
    endfunction

    // scoreboard: push on request handshake, pop and compare on response handshake
    always @(negedge clk) begin
        hs0 = req_valid_0 & req_ready_0;
        hs1 = req_valid_1 & req_ready_1;
        if (rst) begin
            q.delete();
            prev_v = 1'b0;
        end else begin
            if ((rsp_valid_0 | rsp_valid_1) && !prev_v) chk("latency", 64'(cyc - hs_cyc), 64'd2);
            if ((rsp_valid_0 & rsp_ready_0) | (rsp_valid_1 & rsp_ready_1)) begin
                if (q.size() == 0) chk("spurious_rsp", 64'd1, 64'd0);
                else begin
                    e = q.pop_front();
                    chk("rsp_id", 64'(rsp_valid_1), 64'(e.id));
                    chk("rsp_onehot", 64'(rsp_valid_0 & rsp_valid_1), 64'd0);
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("rsp_co", 64'(rsp_co), 64'(e.co));
                end
            end
            if (hs0 | hs1) begin
                r = hs1 ? model(req_a_1, req_b_1, req_op_1) : model(req_a_0, req_b_0, req_op_0);
                q.push_back('{hs1, r[31:0], r[32]});
                glog.push_back(hs1);
                gcyc.push_back(cyc);
                hs_cyc = cyc;
            end
            prev_v = rsp_valid_0 | rsp_valid_1;
        end
    end

    task automatic wait_hs(input logic id);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? (req_valid_1 & req_ready_1) : (req_valid_0 & req_ready_0)) && n < 50);
        if (n >= 50) chk("hs_timeout", 64'd0, 64'd1);
    endtask

    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic op);
        @(posedge clk);
        #1;
        if (id) begin
            req_valid_1 = 1'b1; req_a_1 = a; req_b_1 = b; req_op_1 = op;
        end else begin
            req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b; req_op_0 = op;
        end
        wait_hs(id);
        @(posedge clk);
        #1;
        if (id) req_valid_1 = 1'b0;
        else req_valid_0 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || rsp_valid_0 || rsp_valid_1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        req_valid_0 = 1'b1; req_valid_1 = 1'b0;
        req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
        req_op_0 = 1'b0; req_op_1 = 1'b0;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready_0", 64'(req_ready_0), 64'd0);
        chk("rst_rsp_valid_0", 64'(rsp_valid_0), 64'd0);
        chk("rst_rsp_valid_1", 64'(rsp_valid_1), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_co", 64'(rsp_co), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid_0 = 1'b0;

        issue(1'b0, 32'd5, 32'd3, ADDSUB_OP_ADD);
        drain();
        issue(1'b1, 32'd0, 32'd1, ADDSUB_OP_SUB);
        drain();
        issue(1'b1, 32'd7, 32'd7, ADDSUB_OP_SUB);
        drain();
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, ADDSUB_OP_ADD);
        drain();
        issue(1'b0, 32'h7FFF_FFFF, 32'h8000_0001, ADDSUB_OP_ADD);
        drain();
        issue(1'b1, 32'h0001_0000, 32'h0000_0001, ADDSUB_OP_SUB);
        drain();

        issue(1'b0, 32'd100, 32'd23, ADDSUB_OP_ADD);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_rsp_valid_0", 64'(rsp_valid_0), 64'd0);
        chk("abort_rsp_data", 64'(rsp_data), 64'd0);
        chk("abort_rsp_co", 64'(rsp_co), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 64'(rsp_valid_0 | rsp_valid_1), 64'd0);
        end

        glog.delete();
        gcyc.delete();
        @(posedge clk);
        #1;
        req_valid_0 = 1'b1; req_a_0 = $urandom(); req_b_0 = $urandom(); req_op_0 = 1'($urandom_range(0, 1));
        req_valid_1 = 1'b1; req_a_1 = $urandom(); req_b_1 = $urandom(); req_op_1 = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (hs0) begin req_a_0 = $urandom(); req_b_0 = $urandom(); req_op_0 = 1'($urandom_range(0, 1)); end
            if (hs1) begin req_a_1 = $urandom(); req_b_1 = $urandom(); req_op_1 = 1'($urandom_range(0, 1)); end
        end
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        drain();
        chk("grant_count", 64'(glog.size() >= 7), 64'd1);
        for (int i = 0; i < 6 && i + 1 < glog.size(); i++) begin
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
            chk("grant_order", 64'(glog[i]), 64'd0);
`else
            chk("grant_order", 64'(glog[i]), 64'(i % 2));
`endif
            chk("grant_gap", 64'(gcyc[i + 1] - gcyc[i]), 64'd2);
        end

        rsp_ready_0 = 1'b0;
        issue(1'b0, 32'h1234_5678, 32'h0FED_CBA9, ADDSUB_OP_SUB);
        req_valid_1 = 1'b1; req_a_1 = 32'd40; req_b_1 = 32'd2; req_op_1 = ADDSUB_OP_ADD;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rsp_valid_0 && n < 20);
            chk("bp_rsp_seen", 64'(rsp_valid_0), 64'd1);
        end
        cap = rsp_data;
        chk("bp_data", 64'(cap), 64'(32'h1234_5678 - 32'h0FED_CBA9));
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_hold", 64'(rsp_valid_0), 64'd1);
            chk("bp_data_hold", 64'(rsp_data), 64'(cap));
            chk("bp_no_grant_1", 64'(req_ready_1), 64'd0);
            @(posedge clk);
            #1;
            req_a_0 = $urandom();
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready_0 = 1'b1;
        @(negedge clk);
        chk("bp_grant_on_ready", 64'(req_ready_1), 64'd1);
        chk("bp_valid_at_retire", 64'(rsp_valid_0), 64'd1);
        @(posedge clk);
        #1;
        req_valid_1 = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
